// File: rtl/riscv_pkg.sv
// Shared opcodes, FSM state encoding and datapath select codes for the multi-cycle RV64 controller.
// Pure definitions; no logic, no latency, no flow control.
package riscv_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH1 = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_TRAP      = 4'd9
    } state_t;

    // Moore part of the control word; Mealy gating is applied by the FSM top.
    typedef struct packed {
        logic       pc_write;
        logic       pc_src;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Pure combinational state -> Moore control word; zero latency, no flow control.
// Unused encodings decode to an all-zero word.
module multicycle_ctrl_decode
    import riscv_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_DECODE: begin
                // ALUOut captures OldPC + (imm << 1) as the branch target.
                ctrl.alu_src_b = SRCB_IMM_SH1;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_REG;
                ctrl.alu_op     = ALU_OP_SUB;
                ctrl.pc_src     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_TRAP: begin
                ctrl.illegal = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FSM sequencer: 3-5 cycles per instruction plus one per memory wait cycle.
// Memory stalls via i_mem_ready in FETCH/MEM_READ/MEM_WRITE; all outputs forced low during reset.
module multicycle_control
    import riscv_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [6:0]         i_opcode,
    input  logic               i_zero,
    input  logic               i_mem_ready,
    output logic               o_pc_write,
    output logic               o_pc_src,
    output logic               o_ir_write,
    output logic               o_i_or_d,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_mem_to_reg,
    output logic               o_reg_write,
    output logic               o_alu_src_a,
    output logic [1:0]         o_alu_src_b,
    output logic [1:0]         o_alu_op,
    output logic               o_instr_done,
    output logic               o_illegal,
    output logic [STATE_W-1:0] o_state
);

    state_t state_q;
    state_t state_d;
    logic   is_store_q;
    ctrl_t  ctrl;
    logic   pc_write_g;
    logic   ir_write_g;
    logic   instr_done_g;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_FETCH;
            is_store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                is_store_q <= (i_opcode == OP_SD);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (i_mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (i_opcode)
                    OP_R:          state_d = S_EXEC_R;
                    OP_LD, OP_SD:  state_d = S_MEM_ADDR;
                    OP_BEQ:        state_d = S_BRANCH;
                    default:       state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  state_d = is_store_q ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (i_mem_ready) state_d = S_MEM_WB;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: if (i_mem_ready) state_d = S_FETCH;
            S_EXEC_R:    state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_TRAP;
        endcase
    end

    multicycle_ctrl_decode u_decode (
        .state (state_q),
        .ctrl  (ctrl)
    );

    always_comb begin
        pc_write_g   = ctrl.pc_write;
        ir_write_g   = ctrl.ir_write;
        instr_done_g = ctrl.instr_done;
        if (state_q == S_FETCH) begin
            pc_write_g = i_mem_ready;
            ir_write_g = i_mem_ready;
        end
        if (state_q == S_BRANCH)
            pc_write_g = i_zero;
        if (state_q == S_MEM_WRITE)
            instr_done_g = i_mem_ready;
    end

    // Reset is applied combinationally so no enable can leak out in the reset cycle.
    assign o_pc_write   = i_rst_n & pc_write_g;
    assign o_pc_src     = i_rst_n & ctrl.pc_src;
    assign o_ir_write   = i_rst_n & ir_write_g;
    assign o_i_or_d     = i_rst_n & ctrl.i_or_d;
    assign o_mem_read   = i_rst_n & ctrl.mem_read;
    assign o_mem_write  = i_rst_n & ctrl.mem_write;
    assign o_mem_to_reg = i_rst_n & ctrl.mem_to_reg;
    assign o_reg_write  = i_rst_n & ctrl.reg_write;
    assign o_alu_src_a  = i_rst_n & ctrl.alu_src_a;
    assign o_alu_src_b  = i_rst_n ? ctrl.alu_src_b : 2'b00;
    assign o_alu_op     = i_rst_n ? ctrl.alu_op : 2'b00;
    assign o_instr_done = i_rst_n & instr_done_g;
    assign o_illegal    = i_rst_n & ctrl.illegal;
    assign o_state      = i_rst_n ? STATE_W'(state_q) : '0;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench: builds a per-cycle trace of expected outputs from an instruction list and checks it every cycle.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write;
    logic       mem_to_reg, reg_write, alu_src_a, instr_done, illegal;
    logic [1:0] alu_src_b, alu_op;
    logic [3:0] state;

    multicycle_control #(.STATE_W(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_zero(zero),
        .i_mem_ready(mem_ready), .o_pc_write(pc_write), .o_pc_src(pc_src),
        .o_ir_write(ir_write), .o_i_or_d(i_or_d), .o_mem_read(mem_read),
        .o_mem_write(mem_write), .o_mem_to_reg(mem_to_reg), .o_reg_write(reg_write),
        .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_alu_op(alu_op),
        .o_instr_done(instr_done), .o_illegal(illegal), .o_state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst_n;
        bit [6:0]   op;
        bit         z;
        bit         rdy;
        bit [18:0]  exp;
    } cyc_t;

    cyc_t cyc_q[$];
    int   passed = 0;
    int   total  = 0;
    int   cur    = -1;
    bit   finished = 1'b0;
    int   lat_q[$];

    // Output vector: {pc_write,pc_src,ir_write,i_or_d,mem_read,mem_write,mem_to_reg,
    //                 reg_write,alu_src_a,alu_src_b,alu_op,instr_done,illegal,state}
    function automatic bit [18:0] row(int st, bit rdy, bit z);
        bit pw = 0, ps = 0, ir = 0, iod = 0, mr = 0, mw = 0, m2r = 0, rw = 0, sa = 0, dn = 0, il = 0;
        bit [1:0] sb = 2'b00, op = 2'b00;
        case (st)
            0: begin mr = 1; sb = 2'b01; pw = rdy; ir = rdy; end
            1: sb = 2'b11;
            2: begin sa = 1; sb = 2'b10; end
            3: begin mr = 1; iod = 1; end
            4: begin rw = 1; m2r = 1; dn = 1; end
            5: begin mw = 1; iod = 1; dn = rdy; end
            6: begin sa = 1; op = 2'b10; end
            7: begin rw = 1; dn = 1; end
            8: begin sa = 1; op = 2'b01; ps = 1; pw = z; dn = 1; end
            9: il = 1;
            default: ;
        endcase
        return {pw, ps, ir, iod, mr, mw, m2r, rw, sa, sb, op, dn, il, 4'(st)};
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit [6:0] rop();
        return 7'($urandom_range(0, 127));
    endfunction

    task automatic push(bit r, bit [6:0] op, bit z, bit rdy, int st);
        cyc_t c;
        c.rst_n = r; c.op = op; c.z = z; c.rdy = rdy;
        c.exp = r ? row(st, rdy, z) : 19'd0;
        cyc_q.push_back(c);
    endtask

    task automatic push_reset(int n);
        for (int i = 0; i < n; i++) push(0, rop(), rb(), 1, 0);
    endtask

    // Inputs that the controller must ignore in a given cycle are randomised.
    task automatic add_instr(bit [6:0] op, int fw, int mw, bit z);
        for (int i = 0; i < fw; i++) push(1, rop(), rb(), 0, 0);
        push(1, rop(), rb(), 1, 0);
        push(1, op, rb(), rb(), 1);
        case (op)
            7'b0110011: begin push(1, rop(), rb(), rb(), 6); push(1, rop(), rb(), rb(), 7); end
            7'b0000011: begin
                push(1, rop(), rb(), rb(), 2);
                for (int i = 0; i < mw; i++) push(1, rop(), rb(), 0, 3);
                push(1, rop(), rb(), 1, 3);
                push(1, rop(), rb(), rb(), 4);
            end
            7'b0100011: begin
                push(1, rop(), rb(), rb(), 2);
                for (int i = 0; i < mw; i++) push(1, rop(), rb(), 0, 5);
                push(1, rop(), rb(), 1, 5);
            end
            7'b1100011: push(1, rop(), z, rb(), 8);
            default:    push(1, rop(), rb(), rb(), 9);
        endcase
    endtask

    task automatic check(string name, int got, int want);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s got %0d want %0d", name, got, want);
    endtask

    initial begin
        push_reset(3);
        add_instr(7'b0110011, 0, 0, 0);
        add_instr(7'b0000011, 2, 3, 0);
        add_instr(7'b0100011, 0, 0, 0);
        add_instr(7'b0000011, 0, 0, 0);
        add_instr(7'b1100011, 0, 0, 1);
        add_instr(7'b1100011, 0, 0, 0);
        add_instr(7'b0110011, 1, 0, 0);
        add_instr(7'b0100011, 0, 2, 0);
        // sd interrupted by reset while waiting on memory
        push(1, rop(), rb(), 1, 0);
        push(1, 7'b0100011, rb(), rb(), 1);
        push(1, rop(), rb(), rb(), 2);
        push(1, rop(), rb(), 0, 5);
        push(1, rop(), rb(), 0, 5);
        push(0, rop(), rb(), 1, 0);
        push_reset(1);
        add_instr(7'b0110011, 0, 0, 0);
        add_instr(7'b0010011, 0, 0, 0);
        for (int i = 0; i < 20; i++) push(1, rop(), rb(), rb(), 9);
        push_reset(2);
        add_instr(7'b0110011, 0, 0, 0);

        for (int i = 0; i < cyc_q.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n     = cyc_q[i].rst_n;
            opcode    = cyc_q[i].op;
            zero      = cyc_q[i].z;
            mem_ready = cyc_q[i].rdy;
            cur       = i;
        end
        @(posedge clk);
        #1;
        finished = 1'b1;
    end

    initial begin : compare
        bit [18:0] got;
        int cnt = 0;
        int exp_lat[10] = '{4, 10, 4, 5, 3, 3, 5, 6, 4, 4};
        while (!finished) begin
            @(negedge clk);
            if (finished) break;
            if (cur >= 0) begin
                got = {pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
                       reg_write, alu_src_a, alu_src_b, alu_op, instr_done, illegal, state};
                total++;
                if (got == cyc_q[cur].exp) passed++;
                else $display("FAIL cycle%0d outputs got %b want %b", cur, got, cyc_q[cur].exp);
                if (!cyc_q[cur].rst_n) cnt = 0;
                else if (instr_done) begin lat_q.push_back(cnt + 1); cnt = 0; end
                else cnt++;
            end
        end
        check("retired_count", lat_q.size(), 10);
        for (int i = 0; i < 10; i++)
            check($sformatf("latency%0d", i), (i < lat_q.size()) ? lat_q[i] : -1, exp_lat[i]);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
